// File: rtl/inter_pred_pkg.sv
// Shared types, constants and pixel helpers for the inter-prediction
// reconstruction stage (prediction RAM bank + residual -> clipped 4x4 blocks).
package inter_pred_pkg;
   localparam int NUM_BLK = 24;
   localparam int PIX_W   = 8;
   localparam int RES_W   = 9;
   localparam int NPIX    = 16;
   localparam int IDX_W   = 5;

   typedef logic [NPIX-1:0][PIX_W-1:0] pix_blk_t;
   typedef logic [NPIX-1:0][RES_W-1:0] res_blk_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      pix_blk_t         pix;
   } recon_ent_t;

   // Position of each linear block address in the prediction FSM's Z-order write sequence.
   localparam logic [IDX_W-1:0] WR_RANK [NUM_BLK] = '{
      5'd0,  5'd1,  5'd4,  5'd5,  5'd2,  5'd3,  5'd6,  5'd7,
      5'd8,  5'd9,  5'd12, 5'd13, 5'd10, 5'd11, 5'd14, 5'd15,
      5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

   function automatic logic [PIX_W-1:0] clip_pix(input logic signed [PIX_W+1:0] s);
      if (s < 0)
         return '0;
      else if (s > 255)
         return '1;
      else
         return s[PIX_W-1:0];
   endfunction
endpackage

// File: rtl/inter_pred_recon_fifo.sv
// Two-entry valid/ready FIFO holding reconstructed blocks; flush empties it.
module inter_pred_recon_fifo
   import inter_pred_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       in_valid,
   input  recon_ent_t in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output recon_ent_t out_data,
   output logic [1:0] count
);
   recon_ent_t mem_q [2];
   recon_ent_t mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       pop;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = cnt_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (in_valid) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + 2'(in_valid) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/inter_pred_recon.sv
// Drains completed prediction blocks in linear order, adds residuals, clips,
// and streams reconstructed 4x4 blocks out over valid/ready.
module inter_pred_recon
   import inter_pred_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   start_of_MB,
   input  logic                   blk_wr_done,
   output logic                   out_ram_rd,
   input  logic [16*PIX_W-1:0]    out_ram_rd_data,
   input  logic                   res_valid,
   input  logic [16*RES_W-1:0]    res_data,
   output logic                   res_ready,
   output logic                   recon_valid,
   output logic [16*PIX_W-1:0]    recon_data,
   output logic [IDX_W-1:0]       recon_blk_idx,
   input  logic                   recon_ready,
   output logic                   mb_done
);
   logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
   logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0] blk_q, blk_d;
   logic             inflight_q, inflight_d;
   res_blk_t         res_q, res_d;
   logic             mb_done_q, mb_done_d;

   pix_blk_t         ram_pix;
   recon_ent_t       fifo_in, fifo_out;
   logic             fifo_push, fifo_pop, fifo_valid;
   logic [1:0]       fifo_cnt;
   logic [IDX_W-1:0] rank;
   logic             avail, issue;
   logic [2:0]       occ;

   assign ram_pix = out_ram_rd_data;

   // rank stays at NUM_BLK once the MB is drained, so nothing is ever available.
   always_comb begin
      rank = IDX_W'(NUM_BLK);
      for (int i = 0; i < NUM_BLK; i++)
         if (rd_addr_q == IDX_W'(i)) rank = WR_RANK[i];
   end

   assign avail    = (wr_cnt_q > rank);
   assign fifo_pop = fifo_valid & recon_ready;
   // Counting the same-cycle pop as a freed slot is what allows 1 block/cycle.
   assign occ      = 3'(fifo_cnt) + 3'(inflight_q) - 3'(fifo_pop);
   assign issue    = !rst && ena && !start_of_MB && avail && res_valid && (occ < 3'd2);

   assign out_ram_rd = issue;
   assign res_ready  = issue;
   assign fifo_push  = inflight_q & ~start_of_MB;

   always_comb begin
      fifo_in     = '0;
      fifo_in.idx = blk_q;
      for (int i = 0; i < NPIX; i++)
         fifo_in.pix[i] = clip_pix({2'b00, ram_pix[i]} + {res_q[i][RES_W-1], res_q[i]});
   end

   always_comb begin
      rd_addr_d  = rd_addr_q;
      wr_cnt_d   = wr_cnt_q;
      inflight_d = issue;
      res_d      = issue ? res_blk_t'(res_data) : res_q;
      blk_d      = issue ? rd_addr_q : blk_q;
      mb_done_d  = fifo_pop && (fifo_out.idx == IDX_W'(NUM_BLK-1));
      if (start_of_MB) begin
         rd_addr_d  = '0;
         wr_cnt_d   = IDX_W'(blk_wr_done);
         inflight_d = 1'b0;
      end else begin
         if (issue)
            rd_addr_d = rd_addr_q + 1'b1;
         if (blk_wr_done && (wr_cnt_q < IDX_W'(NUM_BLK)))
            wr_cnt_d = wr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q  <= '0;
         wr_cnt_q   <= '0;
         blk_q      <= '0;
         inflight_q <= 1'b0;
         res_q      <= '0;
         mb_done_q  <= 1'b0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         wr_cnt_q   <= wr_cnt_d;
         blk_q      <= blk_d;
         inflight_q <= inflight_d;
         res_q      <= res_d;
         mb_done_q  <= mb_done_d;
      end
   end

   inter_pred_recon_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (start_of_MB),
      .in_valid  (fifo_push),
      .in_data   (fifo_in),
      .out_valid (fifo_valid),
      .out_ready (recon_ready),
      .out_data  (fifo_out),
      .count     (fifo_cnt)
   );

   assign recon_valid   = fifo_valid;
   assign recon_data    = fifo_out.pix;
   assign recon_blk_idx = fifo_out.idx;
   assign mb_done       = mb_done_q;
endmodule

// File: doc/inter_pred_recon.md
Name: inter_pred_recon

Overview:
Downstream consumer of the inter-prediction output RAM bank (16 single-pixel RAMs, one 4x4 block per address, 24 blocks/MB: 16 luma, 4 Cb, 4 Cr).
- Tracks which blocks the prediction FSM has completed, then drains them in linear address order 0..23.
- Adds the matching 4x4 residual block, clips each pixel to 0..255, and hands 128-bit reconstructed blocks to the frame-store writer over valid/ready.

Parameters:
NUM_BLK, 24, blocks per macroblock (4:2:0).
PIX_W, 8, pixel width.
RES_W, 9, signed residual width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
ena  in  1  global enable; gates issue only.
start_of_MB  in  1  one-cycle pulse; new macroblock.
blk_wr_done  in  1  pulse per completed block write (prediction FSM write strobe for RAM 15).
out_ram_rd  out  1  read strobe to RAM bank; the bank's read address advances on it.
out_ram_rd_data  in  16*PIX_W  RAM i pixel at [8i+7:8i], valid the cycle after out_ram_rd.
res_valid  in  1  residual block available.
res_data  in  16*RES_W  pixel i at [9i+8:9i], raster order in 4x4.
res_ready  out  1  residual pop, equals out_ram_rd.
recon_valid  out  1  reconstructed block available.
recon_data  out  16*PIX_W  clipped pixels, same packing as RAM data.
recon_blk_idx  out  5  block address 0..23 of recon_data.
recon_ready  in  1  consumer accept.
mb_done  out  1  one-cycle pulse when block 23 is accepted.

Behaviour:
- Reset: out_ram_rd=0, res_ready=0, recon_valid=0, recon_data=0, recon_blk_idx=0, mb_done=0, rd_addr=0, wr_cnt=0, inflight=0, FIFO empty.
- wr_cnt (0..24):
  - +1 per blk_wr_done.
  - Saturates at 24.
  - start_of_MB and blk_wr_done in the same cycle → wr_cnt=1.
- Write order is Z-order, not linear.
  - Block a is available when wr_cnt > WR_RANK[a].
  - WR_RANK[0..15] = 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - WR_RANK[16..23] = 16..23.
- Issue (cycle T) when all of the following hold:
  - ena=1,
  - rd_addr < 24,
  - block rd_addr available,
  - res_valid=1,
  - FIFO occupancy + inflight < 2.
- On issue:
  - out_ram_rd=1 and res_ready=1, same cycle; combinational from registered state and inputs.
  - res_data is registered together with rd_addr.
  - rd_addr increments.
- T+1: sum_i = zero-extended RAM pixel + sign-extended residual, computed at 10 bits signed. Clip: <0 → 0, >255 → 255. The result and blk_idx are written into the 2-entry output FIFO.
- T+2: recon_valid=1 at the earliest. Latency from issue to recon_valid is 2 cycles. Sustained throughput is 1 block/cycle when recon_ready is held high.
- Output FIFO:
  - Push and pop in the same cycle are allowed.
  - It never overflows; the credit check guarantees this.
  - recon_data and recon_blk_idx hold stable while recon_valid=1 and recon_ready=0.
- ena=0: no new issue; in-flight reads still complete into the FIFO; the output handshake continues.
- mb_done=1 the cycle after recon_valid & recon_ready with recon_blk_idx=23.
- start_of_MB:
  - rd_addr=0, wr_cnt=0 (or 1, as above).
  - In-flight read discarded; FIFO flushed.
  - Has priority over issue in the same cycle.
- After 24 issues, no further out_ram_rd until start_of_MB.

Decomposition:
- Package inter_pred_pkg:
  - NUM_BLK, PIX_W, RES_W.
  - WR_RANK constant array.
  - clip_pix function (10-bit signed → 8-bit).
  - Pixel/residual block packed typedefs.
- One sub-module: inter_pred_recon_fifo (2-entry valid/ready FIFO with flush).

Test Plan:
- 24 blk_wr_done pulses, res_valid=1, recon_ready=1 → out_ram_rd on 24 consecutive cycles; recon_blk_idx 0..23; first recon_valid 2 cycles after first issue; mb_done once.
- Only 3 blk_wr_done (blocks 0,1,4 written) → blocks 0,1 issued; block 2 stalls until the 5th pulse.
- RAM pixel 250 + residual +20 → 255; pixel 3 + residual -10 → 0; pixel 100 + residual -256 → 0.
- recon_ready=0 for 10 cycles after 2 blocks issued → exactly 2 blocks buffered; no third out_ram_rd; data held stable; resumes 1/cycle on release.
- res_valid toggling every other cycle → issue only on res_valid cycles; residual-to-block pairing checked by recon_data.
- start_of_MB mid-MB (after block 7 issued, FIFO non-empty) → FIFO flushed; rd_addr=0; no mb_done; the next MB completes correctly.
